codec_cfg_seq: RTL and testbench

Automatic WM8731 register-initialisation sequencer that replaces push-button configuration. After reset and a power-up delay, it walks a parametrised table of 16-bit codec words (7-bit register address, 9-bit data) and hands each word to the existing i2c master through its is_send/is_busy/is_done handshake. Failed transfers are retried with a timeout. After init, runtime headphone-volume changes are written automatically. It sits between the top-level codec block and the i2c master; audio streaming is gated on cfg_done.

---
 rtl/codec_pkg.sv | 57 +++++
 rtl/cfg_timer.sv | 29 ++
 rtl/codec_cfg_seq.sv | 245 ++++++++++++++++++++++++
 tb/tb_codec_cfg_seq.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/codec_pkg.sv
// Shared types, WM8731 register map and default initialisation table for the
// codec configuration sequencer.
package codec_pkg;

  // One I2C payload: {reg_addr[6:0], reg_data[8:0]}
  typedef logic [15:0] cfg_word_t;

  typedef enum logic [2:0] {
    PWR_WAIT  = 3'd0,
    LOAD      = 3'd1,
    SEND      = 3'd2,
    WAIT_DONE = 3'd3,
    RUN       = 3'd4,
    ERR       = 3'd5
  } cfg_state_e;

  // WM8731 register addresses
  localparam logic [6:0] R_LLINE   = 7'd0;
  localparam logic [6:0] R_RLINE   = 7'd1;
  localparam logic [6:0] R_LHPOUT  = 7'd2;
  localparam logic [6:0] R_RHPOUT  = 7'd3;
  localparam logic [6:0] R_ANALOG  = 7'd4;
  localparam logic [6:0] R_DIGITAL = 7'd5;
  localparam logic [6:0] R_POWER   = 7'd6;
  localparam logic [6:0] R_FORMAT  = 7'd7;
  localparam logic [6:0] R_SAMPLE  = 7'd8;
  localparam logic [6:0] R_ACTIVE  = 7'd9;
  localparam logic [6:0] R_RESET   = 7'd15;

  // Pack a register address and its 9-bit data into one transfer word
  function automatic cfg_word_t mk_word(input logic [6:0] addr, input logic [8:0] data);
    return {addr, data};
  endfunction

  // True for any register address the WM8731 actually implements
  function automatic logic reg_known(input logic [6:0] addr);
    return (addr inside {R_LLINE, R_RLINE, R_LHPOUT, R_RHPOUT, R_ANALOG, R_DIGITAL,
                         R_POWER, R_FORMAT, R_SAMPLE, R_ACTIVE, R_RESET});
  endfunction

  // Default init order: reset first so the codec starts from a known state,
  // activate last once everything else is programmed. Unused slots are zero.
  localparam cfg_word_t CFG_TABLE [16] = '{
    mk_word(R_RESET,   9'h000),
    mk_word(R_POWER,   9'h007),
    mk_word(R_FORMAT,  9'h01B),
    mk_word(R_SAMPLE,  9'h001),
    mk_word(R_ANALOG,  9'h012),
    mk_word(R_DIGITAL, 9'h000),
    mk_word(R_LHPOUT,  9'h179),
    mk_word(R_RHPOUT,  9'h179),
    mk_word(R_ACTIVE,  9'h001),
    16'h0000, 16'h0000, 16'h0000, 16'h0000,
    16'h0000, 16'h0000, 16'h0000
  };

endpackage

// File: rtl/cfg_timer.sv
// Loadable down-counter with a zero flag. Holds at zero until reloaded.
module cfg_timer #(
  parameter int         W       = 17,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_en,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  // Load has priority; otherwise count down while enabled and non-zero
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= RST_VAL;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/codec_cfg_seq.sv
// WM8731 register-initialisation sequencer. Walks the configuration table
// through the i2c master handshake with retry/timeout, then tracks runtime
// headphone-volume changes and writes them automatically.
module codec_cfg_seq
  import codec_pkg::*;
#(
  parameter int         NUM_REGS    = 9,
  parameter int         CLK_HZ      = 50000000,
  parameter int         PWRUP_US    = 1000,
  parameter int         TIMEOUT_CYC = 100000,
  parameter int         MAX_RETRY   = 3,
  parameter logic [7:0] DEV_ADDR    = 8'h34,
  parameter logic [1:0] AUD_FMT     = 2'd2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        restart,
  input  logic [6:0]  hp_vol,
  input  logic        i2c_is_busy,
  input  logic        i2c_is_done,
  input  logic        i2c_ack_err,
  output logic        i2c_is_send,
  output logic [7:0]  i2c_addr,
  output logic [15:0] i2c_data,
  output logic        cfg_done,
  output logic        cfg_err,
  output logic [3:0]  cur_idx
);

  localparam int PWR_CYC = (CLK_HZ / 1000000) * PWRUP_US;
  localparam int TMR_MAX = (PWR_CYC > TIMEOUT_CYC) ? PWR_CYC : TIMEOUT_CYC;
  localparam int TMR_W   = (TMR_MAX < 2) ? 1 : $clog2(TMR_MAX + 1);

  localparam logic [TMR_W-1:0] TMR_PWR   = TMR_W'(PWR_CYC);
  localparam logic [TMR_W-1:0] TMR_TO    = TMR_W'(TIMEOUT_CYC);
  localparam logic [3:0]       LAST_IDX  = 4'(NUM_REGS - 1);
  localparam logic [7:0]       RETRY_MAX = 8'(MAX_RETRY);

  cfg_state_e r_state, w_state_next;
  logic [3:0] r_idx, w_idx_next;
  cfg_word_t  r_data, w_data_next;
  logic       r_is_send, w_send_next;
  logic [7:0] r_retry, w_retry_next;
  logic       r_done, w_done_next;
  logic       r_err, w_err_next;
  logic [6:0] r_last_vol, w_last_vol_next;
  logic       r_vol_wr, w_vol_wr_next;
  logic [6:0] r_hp_vol;

  cfg_word_t  w_word;
  logic       w_fail;
  logic       w_tmr_load;
  logic       w_tmr_en;
  logic       w_tmr_zero;

  // One counter serves both the power-up delay (reset value) and the
  // per-attempt transfer timeout (reloaded on every new attempt).
  cfg_timer #(
    .W       (TMR_W),
    .RST_VAL (TMR_PWR)
  ) u_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_load     (w_tmr_load),
    .i_load_val (TMR_TO),
    .i_en       (w_tmr_en),
    .o_zero     (w_tmr_zero)
  );

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= PWR_WAIT;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Sequencer datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_idx      <= 4'd0;
      r_data     <= 16'h0000;
      r_is_send  <= 1'b0;
      r_retry    <= 8'd0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_last_vol <= 7'd0;
      r_vol_wr   <= 1'b0;
    end else begin
      r_idx      <= w_idx_next;
      r_data     <= w_data_next;
      r_is_send  <= w_send_next;
      r_retry    <= w_retry_next;
      r_done     <= w_done_next;
      r_err      <= w_err_next;
      r_last_vol <= w_last_vol_next;
      r_vol_wr   <= w_vol_wr_next;
    end
  end

  // Register the volume input so runtime change detection sees a stable value
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hp_vol <= 7'd0;
    end else begin
      r_hp_vol <= hp_vol;
    end
  end

  // Next-state and datapath decode
  always_comb begin
    w_state_next    = r_state;
    w_idx_next      = r_idx;
    w_data_next     = r_data;
    w_send_next     = r_is_send;
    w_retry_next    = r_retry;
    w_done_next     = r_done;
    w_err_next      = r_err;
    w_last_vol_next = r_last_vol;
    w_vol_wr_next   = r_vol_wr;
    w_tmr_load      = 1'b0;
    w_tmr_en        = 1'b0;
    w_fail          = 1'b0;
    w_word          = CFG_TABLE[r_idx];

    case (r_state)
      PWR_WAIT: begin
        w_tmr_en = 1'b1;
        if (w_tmr_zero) begin
          w_state_next = LOAD;
        end
      end

      LOAD: begin
        // Audio format and left headphone volume come from the environment,
        // not the table; the volume loaded here becomes the baseline for RUN.
        if (w_word[15:9] == R_FORMAT) begin
          w_word[3:2] = AUD_FMT;
        end
        if (w_word[15:9] == R_LHPOUT) begin
          w_word[6:0]     = hp_vol;
          w_last_vol_next = hp_vol;
        end
        w_data_next   = w_word;
        w_retry_next  = 8'd0;
        w_vol_wr_next = 1'b0;
        w_tmr_load    = 1'b1;
        w_state_next  = SEND;
      end

      SEND: begin
        // Raise the request only on an idle master; drop it once the master
        // shows it has taken the word.
        w_tmr_en = 1'b1;
        if (!r_is_send) begin
          if (!i2c_is_busy) begin
            w_send_next = 1'b1;
          end
        end else if (i2c_is_busy) begin
          w_send_next  = 1'b0;
          w_state_next = WAIT_DONE;
        end
        if (w_tmr_zero) begin
          w_fail = 1'b1;
        end
      end

      WAIT_DONE: begin
        w_tmr_en = 1'b1;
        if (i2c_is_done) begin
          if (!i2c_ack_err) begin
            if (r_vol_wr) begin
              w_state_next = RUN;
            end else if (r_idx == LAST_IDX) begin
              w_done_next  = 1'b1;
              w_state_next = RUN;
            end else begin
              w_idx_next   = r_idx + 4'd1;
              w_state_next = LOAD;
            end
          end else begin
            w_fail = 1'b1;
          end
        end else if (w_tmr_zero) begin
          w_fail = 1'b1;
        end
      end

      RUN: begin
        if (restart) begin
          w_done_next   = 1'b0;
          w_err_next    = 1'b0;
          w_idx_next    = 4'd0;
          w_vol_wr_next = 1'b0;
          w_state_next  = LOAD;
        end else if (r_hp_vol != r_last_vol) begin
          // LRHPBOTH=1 mirrors the volume to the right channel, LZCEN=0
          w_data_next     = {R_LHPOUT, 2'b10, r_hp_vol};
          w_last_vol_next = r_hp_vol;
          w_retry_next    = 8'd0;
          w_vol_wr_next   = 1'b1;
          w_tmr_load      = 1'b1;
          w_state_next    = SEND;
        end
      end

      ERR: begin
        if (restart) begin
          w_done_next   = 1'b0;
          w_err_next    = 1'b0;
          w_idx_next    = 4'd0;
          w_vol_wr_next = 1'b0;
          w_state_next  = LOAD;
        end
      end

      default: begin
        w_state_next = PWR_WAIT;
      end
    endcase

    // NACK or timeout: resend the same word until retries run out. A failed
    // volume write is non-fatal and returns to RUN with the error flagged.
    if (w_fail) begin
      w_send_next = 1'b0;
      if (r_retry < RETRY_MAX) begin
        w_retry_next = r_retry + 8'd1;
        w_tmr_load   = 1'b1;
        w_state_next = SEND;
      end else begin
        w_err_next   = 1'b1;
        w_state_next = r_vol_wr ? RUN : ERR;
      end
    end
  end

  assign i2c_is_send = r_is_send;
  assign i2c_addr    = DEV_ADDR;
  assign i2c_data    = r_data;
  assign cfg_done    = r_done;
  assign cfg_err     = r_err;
  assign cur_idx     = r_idx;

endmodule

// File: tb/tb_codec_cfg_seq.sv
// Directed bench for codec_cfg_seq with a behavioural i2c master that can
// NACK or ignore selected words.
module tb_codec_cfg_seq;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        restart = 1'b0;
  logic [6:0]  hp_vol = 7'h79;
  logic        i2c_is_busy = 1'b0;
  logic        i2c_is_done = 1'b0;
  logic        i2c_ack_err = 1'b0;
  logic        i2c_is_send;
  logic [7:0]  i2c_addr;
  logic [15:0] i2c_data;
  logic        cfg_done;
  logic        cfg_err;
  logic [3:0]  cur_idx;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  codec_cfg_seq #(
    .NUM_REGS    (9),
    .CLK_HZ      (50000000),
    .PWRUP_US    (1),
    .TIMEOUT_CYC (200),
    .MAX_RETRY   (3),
    .DEV_ADDR    (8'h34),
    .AUD_FMT     (2'd0)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .restart     (restart),
    .hp_vol      (hp_vol),
    .i2c_is_busy (i2c_is_busy),
    .i2c_is_done (i2c_is_done),
    .i2c_ack_err (i2c_ack_err),
    .i2c_is_send (i2c_is_send),
    .i2c_addr    (i2c_addr),
    .i2c_data    (i2c_data),
    .cfg_done    (cfg_done),
    .cfg_err     (cfg_err),
    .cur_idx     (cur_idx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  // Advance n cycles, landing 1 time unit after the rising edge
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: log every new request (rising edge of is_send)
  logic [15:0] sent_q[$];
  logic [3:0]  idx_q[$];
  logic        prev_send = 1'b0;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (i2c_is_send && !prev_send) begin
        sent_q.push_back(i2c_data);
        idx_q.push_back(cur_idx);
        $display("[%0d] i2c write addr=%02h word=%04h idx=%0d", cyc, i2c_addr, i2c_data, cur_idx);
      end
      prev_send = i2c_is_send;
    end
  end

  // i2c master model: busy for 4 cycles, then a done pulse
  int          busy_cnt = 0;
  logic        nack_now = 1'b0;
  int          nack_left = 0;
  logic [15:0] nack_word = 16'h1001;
  logic        ign_en = 1'b0;
  logic [15:0] ign_word = 16'h0000;
  int          last_done_cyc = 0;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      i2c_is_done = 1'b0;
      i2c_ack_err = 1'b0;
      if (busy_cnt > 0) begin
        busy_cnt--;
        if (busy_cnt == 0) begin
          i2c_is_busy   = 1'b0;
          i2c_is_done   = 1'b1;
          i2c_ack_err   = nack_now;
          last_done_cyc = cyc;
        end
      end else if (i2c_is_send && !(ign_en && (i2c_data == ign_word))) begin
        nack_now = (i2c_data == nack_word) && (nack_left > 0);
        if (nack_now) nack_left--;
        i2c_is_busy = 1'b1;
        busy_cnt    = 4;
      end
    end
  end

  logic [15:0] exp_init [11] = '{16'h1E00, 16'h0C07, 16'h0E13, 16'h1001, 16'h1001, 16'h1001,
                                 16'h0812, 16'h0A00, 16'h0579, 16'h0779, 16'h1201};
  logic [15:0] exp_rerun [9] = '{16'h1E00, 16'h0C07, 16'h0E13, 16'h1001, 16'h0812,
                                 16'h0A00, 16'h0560, 16'h0779, 16'h1201};

  initial begin
    int k;
    int rise_cyc;
    int n_r7;
    int n0;
    logic found;

    // Reset state
    step(3);
    check_val("rst_send", i2c_is_send, 0);
    check_val("rst_data", i2c_data, 16'h0000);
    check_val("rst_done", cfg_done, 0);
    check_val("rst_err", cfg_err, 0);
    check_val("rst_idx", cur_idx, 0);
    check_val("dev_addr", i2c_addr, 8'h34);

    // Init with two NACKs on entry 3
    nack_left = 2;
    sent_q.delete();
    idx_q.delete();
    reset_n = 1'b1;
    step(50);
    check_val("pwrup_quiet", sent_q.size(), 0);
    k = 0;
    while (!cfg_done && k < 3000) begin
      step(1);
      k++;
    end
    rise_cyc = cyc;
    check_val("init_done", cfg_done, 1);
    check_val("done_lat", rise_cyc - last_done_cyc, 1);
    check_val("init_cnt", sent_q.size(), 11);
    for (int i = 0; i < 11 && i < sent_q.size(); i++) begin
      check_val($sformatf("init_w%0d", i), sent_q[i], exp_init[i]);
    end
    if (idx_q.size() > 6) check_val("idx_after_nack", idx_q[6], 4);
    check_val("init_err", cfg_err, 0);
    check_val("init_idx", cur_idx, 8);

    // Runtime volume change
    sent_q.delete();
    step(20);
    check_val("run_quiet", sent_q.size(), 0);
    hp_vol = 7'h60;
    step(60);
    check_val("vol_cnt", sent_q.size(), 1);
    if (sent_q.size() > 0) check_val("vol_word", sent_q[0], 16'h0560);
    step(100);
    check_val("vol_once", sent_q.size(), 1);
    check_val("vol_done", cfg_done, 1);

    // Entry 2 never answered: timeout retries, then error
    ign_word = 16'h0E13;
    ign_en   = 1'b1;
    sent_q.delete();
    restart = 1'b1;
    step(1);
    restart = 1'b0;
    check_val("restart_clr_done", cfg_done, 0);
    k = 0;
    while (!cfg_err && k < 3000) begin
      step(1);
      k++;
    end
    check_val("to_err", cfg_err, 1);
    n_r7 = 0;
    foreach (sent_q[i]) if (sent_q[i] == 16'h0E13) n_r7++;
    check_val("to_tries", n_r7, 4);
    check_val("to_send_low", i2c_is_send, 0);
    check_val("to_idx", cur_idx, 2);
    n0 = sent_q.size();
    step(300);
    check_val("err_quiet", sent_q.size(), n0);
    check_val("err_sticky", cfg_err, 1);

    // Restart from ERR, then reset in the middle of entry 5
    ign_en = 1'b0;
    sent_q.delete();
    restart = 1'b1;
    step(1);
    restart = 1'b0;
    check_val("restart_clr_err", cfg_err, 0);
    found = 1'b0;
    k = 0;
    while (!found && k < 1000) begin
      step(1);
      k++;
      if (i2c_is_send && cur_idx == 4'd5) found = 1'b1;
    end
    check_val("reach_entry5", found, 1);
    if (sent_q.size() > 0) check_val("restart_first", sent_q[0], 16'h1E00);
    #2;
    reset_n = 1'b0;
    #1;
    check_val("async_send", i2c_is_send, 0);
    check_val("async_done", cfg_done, 0);
    check_val("async_idx", cur_idx, 0);
    step(3);
    sent_q.delete();
    reset_n = 1'b1;
    step(50);
    check_val("rerun_quiet", sent_q.size(), 0);
    k = 0;
    while (!cfg_done && k < 3000) begin
      step(1);
      k++;
    end
    check_val("rerun_done", cfg_done, 1);
    check_val("rerun_cnt", sent_q.size(), 9);
    for (int i = 0; i < 9 && i < sent_q.size(); i++) begin
      check_val($sformatf("rerun_w%0d", i), sent_q[i], exp_rerun[i]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
